rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Round-robin arbiter that shares one resource among eight requesters and drives a one-hot grant through the team's `decoder_3to8`. A registered 3-bit grant index feeds the decoder. The decoder output is gated by a grant-valid flag. The block sits in front of any shared 8-way resource: a bus, a memory port, or a display digit slot.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive cycles one grant may be held. Legal range 1..255.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset: synchronous, active-high.
- `req`  in  8  request vector. Bit i is held high by requester i for as long as it wants the resource.
- `gnt`  out  8  one-hot grant, or all zeros when no grant is active.
- `gnt_idx`  out  3  index of the current or last granted requester.
- `gnt_valid`  out  1  high while a grant is active.

## Operation
- State machine with two states.
  - IDLE: no grant active.
  - GRANT: grant held by requester `gnt_idx`.
- Rotating pointer `ptr`, 3 bits, holds the highest-priority index.
  - Search order is ptr, ptr+1, …, ptr+7, all modulo 8 with natural 3-bit wrap.
- IDLE → GRANT when `req != 0`.
  - `gnt_idx` takes the first set bit in search order.
  - `gnt_valid` goes to 1.
  - `hold_cnt` goes to 1.
- GRANT → IDLE when either of these is true:
  - release: `req[gnt_idx] == 0`;
  - timeout: `hold_cnt == HOLD_MAX`.
- On leaving GRANT:
  - `ptr` ← `gnt_idx + 1`, wrapping 7→0;
  - `gnt_valid` ← 0;
  - `gnt_idx` keeps its value.
- Otherwise GRANT stays GRANT and `hold_cnt` increments. `hold_cnt` is 8 bits and never exceeds `HOLD_MAX`.
- A timed-out requester that still asserts req competes normally in the next IDLE cycle. It has the lowest priority at that point, but wins if it is the only requester.
- Requests from non-granted requesters that rise or fall during GRANT are ignored until the next IDLE cycle.
- `gnt = gnt_valid ? decoder_3to8(gnt_idx) : 8'h00`.
  - This is combinational from registers only; there is no input-to-output combinational path.
- Reset, and reset asserted mid-grant, takes effect at the next rising edge. After it:
  - state = IDLE, `ptr` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `gnt` = 8'h00, `hold_cnt` = 0.
  - Any grant in progress is dropped without a pointer update.

## Timing
- Grant latency: a request sampled at edge N while in IDLE gives `gnt` valid after edge N.
  - That is visible in cycle N+1, one cycle after the request.
- Release latency: `req[gnt_idx]` sampled low at edge M gives `gnt` = 0 after edge M.
- Turnaround: exactly one IDLE cycle (`gnt` = 0) separates any two grants, including a re-grant to the same requester.
- Maximum continuous grant length is `HOLD_MAX` cycles.
- Worst-case wait for a continuously requesting client is 7 × (`HOLD_MAX` + 1) cycles plus 1.
- Release and timeout in the same cycle: a single transition; the pointer is updated once.
- A requester dropping req in the very cycle it would be granted gets no grant if its bit is 0 at the sampling edge.

## Structure
- Shared package holds:
  - state encoding constants `ST_IDLE` = 1'b0, `ST_GRANT` = 1'b1;
  - the 3-bit index width and requester count (8).
- One sub-module instance: `decoder_3to8` (existing), port order (in, out). It converts `gnt_idx` to a one-hot vector before gating.
- Priority search is a combinational function inside the arbiter: rotate `req` right by `ptr`, find the first set bit, then add `ptr` back.

## Test plan
- Reset, then single requester: `rst` for 2 cycles, then `req` = 8'h04 held.
  - `gnt` = 8'h04 and `gnt_idx` = 2 one cycle later.
  - Then drop req; `gnt` = 8'h00 the next cycle and `ptr` = 3.
- Rotation: from `ptr` = 0, all requesters asserting, each releasing after 2 cycles of grant.
  - Grant order is 0,1,2,…,7,0, with one zero-grant cycle between consecutive grants.
- Wrap-around: set `ptr` = 7 via a grant/release of requester 6, then `req` = 8'h81.
  - Requester 7 is granted first, then requester 0.
- Timeout: `HOLD_MAX` = 4, `req` = 8'h03, requester 0 never releases.
  - `gnt` = 8'h01 for exactly 4 cycles, one idle cycle, then `gnt` = 8'h02.
  - With `req` = 8'h01 only: requester 0 is re-granted after a one-cycle gap.
- Reset mid-grant: assert `rst` during the 2nd cycle of a grant to requester 5.
  - All outputs are 0 and `ptr` = 0 after the edge.
  - With `req` = 8'h21 still held after reset releases, requester 0 wins.
- Late request ignored: grant requester 1, raise `req[0]` mid-grant, release 1.
  - Requester 0 is not granted before requester 2 when `req` = 8'h05.
  - Then requester 0 is granted next.

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding and
// requester/index sizing.
package rr_arbiter_8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_8_decoder_3to8.sv
// 3-to-8 one-hot decoder shared across the codebase; out has exactly one bit
// set, selected by in.
module decoder_3to8 (
    input  logic [2:0] in,
    output logic [7:0] out
);

    assign out = 8'b0000_0001 << in;

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a bounded hold time. The grant is
// decoded from a registered index, so no request input reaches gnt directly.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               valid_nxt;
    logic [7:0]         hold_cnt, hold_cnt_nxt;
    logic [NUM_REQ-1:0] dec;

    // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the
    // rotation; 3-bit arithmetic supplies the modulo-8 wrap.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [IDX_W-1:0]     off;
        dbl = {r, r} >> p;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i[IDX_W-1:0];
        end
        return p + off;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            hold_cnt  <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        idx_nxt      = gnt_idx;
        valid_nxt    = gnt_valid;
        hold_cnt_nxt = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (req != '0) begin
                    state_nxt    = ST_GRANT;
                    idx_nxt      = rr_pick(req, ptr);
                    valid_nxt    = 1'b1;
                    hold_cnt_nxt = 8'd1;
                end
            end
            ST_GRANT: begin
                // Release and timeout share one exit, so ptr advances once.
                if (!req[gnt_idx] || hold_cnt == HOLD_LIM) begin
                    state_nxt    = ST_IDLE;
                    ptr_nxt      = gnt_idx + 3'd1;
                    valid_nxt    = 1'b0;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    decoder_3to8 u_dec (
        .in  (gnt_idx),
        .out (dec)
    );

    assign gnt = gnt_valid ? dec : '0;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed vector table, hand-written
// corner sequences, and randomized traffic against a reference model.
module tb_rr_arbiter_8;

    localparam int HM = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int checks = 0;
    int errors = 0;

    rr_arbiter_8 #(.HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } vec_t;

    vec_t vq[$];

    // Reference model: grant holder, last index, priority pointer, hold count.
    int m_valid = 0;
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic model_step(input logic [7:0] r, input logic rs);
        if (rs) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_valid == 0) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (r[c] && m_valid == 0) begin
                    m_valid = 1; m_idx = c; m_cnt = 1;
                end
            end
        end else if (r[m_idx] == 1'b0 || m_cnt == HM) begin
            m_valid = 0;
            m_ptr   = (m_idx + 1) % 8;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        logic [7:0] eg;
        eg = (m_valid != 0) ? (8'h01 << m_idx) : 8'h00;
        chk({nm, ".gnt"}, gnt, eg);
        chk({nm, ".idx"}, {5'd0, gnt_idx}, 8'(m_idx));
        chk({nm, ".vld"}, {7'd0, gnt_valid}, 8'(m_valid));
    endtask

    // One clock: drive at the falling edge, model on the rising edge, sample
    // at the following falling edge.
    task automatic cycle(input logic [7:0] r, input logic rs, input string nm);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        @(negedge clk);
        chk_model(nm);
    endtask

    task automatic add(input logic rs, input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] i, input logic v);
        vec_t e;
        e.rst = rs; e.req = r; e.gnt = g; e.idx = i; e.vld = v;
        vq.push_back(e);
    endtask

    initial begin
        logic [7:0] r;
        logic       rs;
        rst = 1'b1;
        req = 8'h00;

        // Reset, single requester, pointer observed through the next pick.
        add(1, 8'h00, 8'h00, 0, 0);
        add(1, 8'h00, 8'h00, 0, 0);
        add(0, 8'h04, 8'h04, 2, 1);
        add(0, 8'h04, 8'h04, 2, 1);
        add(0, 8'h00, 8'h00, 2, 0);
        add(0, 8'h14, 8'h10, 4, 1);
        add(0, 8'h00, 8'h00, 4, 0);
        // Wrap-around: requester 6 moves ptr to 7, then 7 beats 0.
        add(0, 8'h40, 8'h40, 6, 1);
        add(0, 8'h00, 8'h00, 6, 0);
        add(0, 8'h81, 8'h80, 7, 1);
        add(0, 8'h01, 8'h00, 7, 0);
        add(0, 8'h01, 8'h01, 0, 1);
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h80, 8'h80, 7, 1);
        add(0, 8'h00, 8'h00, 7, 0);
        // Timeout with requester 0 never releasing.
        add(0, 8'h03, 8'h01, 0, 1);
        add(0, 8'h03, 8'h01, 0, 1);
        add(0, 8'h03, 8'h01, 0, 1);
        add(0, 8'h03, 8'h01, 0, 1);
        add(0, 8'h03, 8'h00, 0, 0);
        add(0, 8'h03, 8'h02, 1, 1);
        add(0, 8'h01, 8'h00, 1, 0);
        // Sole requester re-granted after a one-cycle gap.
        add(0, 8'h01, 8'h01, 0, 1);
        add(0, 8'h01, 8'h01, 0, 1);
        add(0, 8'h01, 8'h01, 0, 1);
        add(0, 8'h01, 8'h01, 0, 1);
        add(0, 8'h01, 8'h00, 0, 0);
        add(0, 8'h01, 8'h01, 0, 1);
        add(0, 8'h00, 8'h00, 0, 0);

        @(negedge clk);
        for (int v = 0; v < vq.size(); v++) begin
            req = vq[v].req;
            rst = vq[v].rst;
            @(posedge clk);
            model_step(vq[v].req, vq[v].rst);
            @(negedge clk);
            chk($sformatf("vec%0d.gnt", v), gnt, vq[v].gnt);
            chk($sformatf("vec%0d.idx", v), {5'd0, gnt_idx}, {5'd0, vq[v].idx});
            chk($sformatf("vec%0d.vld", v), {7'd0, gnt_valid}, {7'd0, vq[v].vld});
        end

        // Rotation from ptr 0 with everyone requesting.
        cycle(8'h80, 0, "rot.pre_g");
        cycle(8'h00, 0, "rot.pre_r");
        for (int g = 0; g < 9; g++) begin
            logic [7:0] one;
            one = 8'h01 << (g % 8);
            cycle(8'hFF, 0, $sformatf("rot%0d.a", g));
            chk($sformatf("rot%0d.order", g), gnt, one);
            cycle(8'hFF, 0, $sformatf("rot%0d.b", g));
            cycle(8'hFF & ~one, 0, $sformatf("rot%0d.gap", g));
            chk($sformatf("rot%0d.gap0", g), gnt, 8'h00);
        end

        // Reset in the second cycle of a grant to requester 5.
        cycle(8'h20, 0, "rstmid.g1");
        chk("rstmid.granted", gnt, 8'h20);
        cycle(8'h20, 0, "rstmid.g2");
        cycle(8'h20, 1, "rstmid.rst");
        chk("rstmid.gnt0", gnt, 8'h00);
        chk("rstmid.idx0", {5'd0, gnt_idx}, 8'h00);
        cycle(8'h21, 0, "rstmid.after");
        chk("rstmid.req0wins", gnt, 8'h01);
        cycle(8'h00, 0, "rstmid.rel");

        // Request raised mid-grant waits behind requester 2.
        cycle(8'h02, 0, "late.g1");
        chk("late.g1gnt", gnt, 8'h02);
        cycle(8'h03, 0, "late.raise0");
        cycle(8'h05, 0, "late.rel1");
        cycle(8'h05, 0, "late.g2");
        chk("late.req2first", gnt, 8'h04);
        cycle(8'h01, 0, "late.rel2");
        cycle(8'h01, 0, "late.g0");
        chk("late.req0next", gnt, 8'h01);
        cycle(8'h00, 0, "late.idle");

        // Randomized traffic: requests mostly held, occasional reset.
        r = 8'h00;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            rs = ($urandom_range(79) == 0);
            cycle(r, rs, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
